// File: rtl/otter_decode_stage.sv
// OTTER pipeline decode stage: turns the IF/ID instruction into control signals and
// registers them into ID/EX, with valid/ready handshaking, a load-use interlock and squash.
module otter_decode_stage #(
  parameter int ENABLE_M         = 0,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int XLEN             = 32,
  localparam int ALU_FUN_W       = 4 + ENABLE_M
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 if_valid,
  input  logic [XLEN-1:0]      if_ir,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 id_ready,
  input  logic                 ex_ready,
  input  logic                 flush,
  input  logic                 int_taken,
  output logic                 ex_valid,
  output logic [ALU_FUN_W-1:0] ex_alu_fun,
  output logic [1:0]           ex_alu_srca,
  output logic [2:0]           ex_alu_srcb,
  output logic [1:0]           ex_rf_wr_sel,
  output logic                 ex_reg_write,
  output logic                 ex_mem_we,
  output logic                 ex_mem_rden,
  output logic                 ex_jump,
  output logic                 ex_branch,
  output logic                 ex_illegal,
  output logic [4:0]           ex_rs1,
  output logic [4:0]           ex_rs2,
  output logic [4:0]           ex_rd,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_ir
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // Counter reload leaves one bubble already accounted for by the hazard cycle itself.
  localparam logic [1:0] BUB_RELOAD =
    (LOAD_USE_BUBBLES > 0) ? 2'(LOAD_USE_BUBBLES - 1) : 2'd0;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = if_ir[6:0];
  assign rd     = if_ir[11:7];
  assign f3     = if_ir[14:12];
  assign rs1    = if_ir[19:15];
  assign rs2    = if_ir[24:20];
  assign f7     = if_ir[31:25];

  logic [3:0]           alu_base;
  logic [ALU_FUN_W-1:0] alu_fun_d;
  logic [1:0]           srca_d;
  logic [2:0]           srcb_d;
  logic [1:0]           wr_sel_d;
  logic                 reg_write_d, mem_we_d, mem_rden_d, jump_d, branch_d, illegal_d;
  logic                 uses_rs1, uses_rs2, m_op;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    alu_base    = 4'b0000;
    srca_d      = 2'b00;
    srcb_d      = 3'b000;
    wr_sel_d    = 2'b00;
    reg_write_d = 1'b0;
    mem_we_d    = 1'b0;
    mem_rden_d  = 1'b0;
    jump_d      = 1'b0;
    branch_d    = 1'b0;
    illegal_d   = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    m_op        = 1'b0;

    case (opcode)
      OP_R: begin
        alu_base    = {if_ir[30], f3};
        wr_sel_d    = 2'b11;
        reg_write_d = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        if (f7 == F7_BASE) begin
          illegal_d = 1'b0;
        end else if (f7 == F7_ALT) begin
          illegal_d = !((f3 == 3'b000) || (f3 == 3'b101));
        end else if ((f7 == F7_MUL) && (ENABLE_M != 0)) begin
          m_op = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_IMM: begin
        alu_base    = {(f3 == 3'b101) ? if_ir[30] : 1'b0, f3};
        srcb_d      = 3'b001;
        wr_sel_d    = 2'b11;
        reg_write_d = 1'b1;
        uses_rs1    = 1'b1;
        // Only the shifts carry a funct7; other I-ALU ops use those bits as immediate.
        if (f3 == 3'b001) begin
          illegal_d = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          illegal_d = (f7 != F7_BASE) && (f7 != F7_ALT);
        end
      end
      OP_LOAD: begin
        srcb_d      = 3'b001;
        wr_sel_d    = 2'b10;
        reg_write_d = 1'b1;
        mem_rden_d  = 1'b1;
        uses_rs1    = 1'b1;
      end
      OP_STORE: begin
        srcb_d   = 3'b010;
        mem_we_d = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        branch_d = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JALR: begin
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
        uses_rs1    = 1'b1;
      end
      OP_JAL: begin
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
      end
      OP_LUI: begin
        alu_base    = 4'b1001;
        srca_d      = 2'b01;
        wr_sel_d    = 2'b11;
        reg_write_d = 1'b1;
      end
      OP_AUIPC: begin
        srca_d      = 2'b01;
        srcb_d      = 3'b011;
        wr_sel_d    = 2'b11;
        reg_write_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase

    alu_fun_d = ALU_FUN_W'(alu_base);
    if (m_op) alu_fun_d = ALU_FUN_W'({2'b10, f3});

    // An illegal instruction still travels down as valid so EX can raise the trap,
    // but it must not touch architectural state.
    if (illegal_d) begin
      reg_write_d = 1'b0;
      mem_we_d    = 1'b0;
      mem_rden_d  = 1'b0;
      jump_d      = 1'b0;
      branch_d    = 1'b0;
    end
  end

  logic [1:0] bub_cnt;
  logic       hazard, adv, squash;

  assign hazard = (LOAD_USE_BUBBLES > 0) && if_valid && ex_valid && ex_mem_rden &&
                  ex_reg_write && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  assign adv      = !ex_valid || ex_ready;
  assign squash   = flush || int_taken;
  assign id_ready = adv && !hazard && (bub_cnt == 2'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_valid     <= 1'b0;
      ex_alu_fun   <= '0;
      ex_alu_srca  <= '0;
      ex_alu_srcb  <= '0;
      ex_rf_wr_sel <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_we    <= 1'b0;
      ex_mem_rden  <= 1'b0;
      ex_jump      <= 1'b0;
      ex_branch    <= 1'b0;
      ex_illegal   <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_pc        <= '0;
      ex_ir        <= '0;
      bub_cnt      <= 2'd0;
    end else if (squash) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      ex_valid <= 1'b0;
      bub_cnt  <= 2'd0;
    end else if (!adv) begin
      ex_valid <= ex_valid;
    end else if (bub_cnt != 2'd0) begin
      ex_valid <= 1'b0;
      bub_cnt  <= bub_cnt - 2'd1;
    end else if (hazard) begin
      ex_valid <= 1'b0;
      bub_cnt  <= BUB_RELOAD;
    end else begin
      ex_valid     <= if_valid;
      ex_alu_fun   <= alu_fun_d;
      ex_alu_srca  <= srca_d;
      ex_alu_srcb  <= srcb_d;
      ex_rf_wr_sel <= wr_sel_d;
      ex_reg_write <= reg_write_d;
      ex_mem_we    <= mem_we_d;
      ex_mem_rden  <= mem_rden_d;
      ex_jump      <= jump_d;
      ex_branch    <= branch_d;
      ex_illegal   <= illegal_d;
      ex_rs1       <= rs1;
      ex_rs2       <= rs2;
      ex_rd        <= rd;
      ex_pc        <= if_pc;
      ex_ir        <= if_ir;
    end
  end

endmodule
